// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Signal bundle between the I/D cache miss logic, main memory
//               and the memory arbiter.
//               master : request side (caches + memory model) drives requests,
//                        store data and memory read data.
//               slave  : the arbiter; drives memory requests, fill data and
//                        completion pulses.
// Signals     : i_miss/i_addr        I-cache miss request + byte address
//               d_miss/d_addr        D-cache miss request + byte address
//               d_wr/d_wdata         D-cache write-through store
//               mem_rdata/mem_valid  memory read return
//               mem_en/mem_wr/mem_addr/mem_wdata  memory request
//               fill_data/fill_word/i_fill_we/d_fill_we  block fill to caches
//               i_done/d_done/d_wr_ack  one-cycle completion pulses
//               busy                 arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we;
    logic        d_fill_we;
    logic        i_done;
    logic        d_done;
    logic        d_wr_ack;
    logic        busy;

    modport master (
        output i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy
    );

    modport slave (
        input  i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
               i_fill_we, d_fill_we, i_done, d_done, d_wr_ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Non-preemptive arbiter sharing one main-memory port between
//               the I-cache and D-cache. Grants d_wr > d_miss > i_miss from
//               IDLE. A store is a single write cycle; a miss is an 8-word
//               block read (issued on 8 consecutive cycles, data returning
//               4 cycles later) streamed into the owning cache.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus    - mem_arbiter_if.slave (requests, memory, fills, pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [15:0] c_BLOCK_MASK = 16'hFFF0;
    localparam logic [2:0]  c_LAST_WORD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_ownerD;      // 1: D-cache owns the current operation
    logic [15:0] r_base;
    logic [2:0]  r_issueCnt;    // k
    logic [2:0]  r_retCnt;      // r
    logic        r_issueDone;   // all 8 reads issued; k itself never wraps
    logic        r_iDone;
    logic        r_dDone;

    logic        w_wrReq;
    logic        w_dReq;
    logic        w_iReq;
    logic        w_grant;
    logic        w_grantD;
    logic [15:0] w_reqAddr;
    logic        w_lastRet;

    // A requester keeps its miss line high through the done cycle, so the
    // just-finished request is masked there; any other pending request may
    // be granted straight away.
    always_comb begin
        w_wrReq   = bus.d_wr;
        w_dReq    = bus.d_miss & ~r_dDone;
        w_iReq    = bus.i_miss & ~r_iDone;
        w_grant   = w_wrReq | w_dReq | w_iReq;
        w_grantD  = w_wrReq | w_dReq;
        w_reqAddr = w_grantD ? bus.d_addr : bus.i_addr;
        w_lastRet = bus.mem_valid && (r_retCnt == c_LAST_WORD);
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_wrReq) begin
                    w_nextState = WRITE;
                end else if (w_dReq || w_iReq) begin
                    w_nextState = FILL;
                end
            end
            WRITE: w_nextState = IDLE;
            FILL: begin
                if (w_lastRet) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ownerD    <= 1'b0;
            r_base      <= 16'd0;
            r_issueCnt  <= 3'd0;
            r_retCnt    <= 3'd0;
            r_issueDone <= 1'b0;
            r_iDone     <= 1'b0;
            r_dDone     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_iDone <= 1'b0;
            r_dDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_ownerD    <= w_grantD;
                        r_base      <= w_reqAddr & c_BLOCK_MASK;
                        r_issueCnt  <= 3'd0;
                        r_retCnt    <= 3'd0;
                        r_issueDone <= 1'b0;
                    end
                end
                FILL: begin
                    if (!r_issueDone) begin
                        if (r_issueCnt == c_LAST_WORD) begin
                            r_issueDone <= 1'b1;
                        end else begin
                            r_issueCnt <= r_issueCnt + 3'd1;
                        end
                    end
                    if (bus.mem_valid) begin
                        if (w_lastRet) begin
                            r_iDone <= ~r_ownerD;
                            r_dDone <= r_ownerD;
                        end else begin
                            r_retCnt <= r_retCnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 16'd0;
        bus.mem_wdata = 16'd0;
        bus.fill_data = 16'd0;
        bus.fill_word = 3'd0;
        bus.i_fill_we = 1'b0;
        bus.d_fill_we = 1'b0;
        bus.d_wr_ack  = 1'b0;
        case (r_state)
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_wr_ack  = 1'b1;
            end
            FILL: begin
                if (!r_issueDone) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = r_base + {12'd0, r_issueCnt, 1'b0};
                end
                if (bus.mem_valid) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_word = r_retCnt;
                    bus.i_fill_we = ~r_ownerD;
                    bus.d_fill_we = r_ownerD;
                end
            end
            default: ;
        endcase
        bus.i_done = r_iDone;
        bus.d_done = r_dDone;
        bus.busy   = (r_state != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Memory model returns
//               addr ^ 0x5A5A four cycles after each read issue. Expected
//               reads, writes, fills and done pulses are queued as stimulus
//               is applied and compared by a monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        owner;     // 1 = D
        logic [2:0]  word;
        logic [15:0] data;
    } fill_t;

    int          checks     = 0;
    int          failures   = 0;
    int          cycle      = 0;
    int          firstIssue = 0;
    int          readsSeen  = 0;
    int          writesSeen = 0;
    int          dFillSeen  = 0;

    logic [15:0] expRdQ[$];
    fill_t       expFillQ[$];
    logic [31:0] expWrQ[$];
    logic        expDoneQ[$];

    logic        pv[4];
    logic [15:0] pa[4];
    logic        capV = 1'b0;
    logic [15:0] capA = 16'd0;
    logic        strayValid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expectFill(input logic owner, input logic [15:0] addr);
        logic [15:0] base;
        fill_t f;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            expRdQ.push_back(base + 16'(2 * k));
            f.owner = owner;
            f.word  = 3'(k);
            f.data  = (base + 16'(2 * k)) ^ 16'h5A5A;
            expFillQ.push_back(f);
        end
        expDoneQ.push_back(owner);
    endtask

    task automatic serveI();
        logic seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.i_done) begin seen = 1'b1; break; end
        end
        chk("i_done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        bus.i_miss = 1'b0;
    endtask

    task automatic serveD();
        logic seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.d_done) begin seen = 1'b1; break; end
        end
        chk("d_done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        bus.d_miss = 1'b0;
    endtask

    task automatic serveW();
        logic seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.d_wr_ack) begin seen = 1'b1; break; end
        end
        chk("d_wr_ack_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        bus.d_wr = 1'b0;
    endtask

    task automatic waitFill(input logic [2:0] w);
        logic seen = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if ((bus.i_fill_we || bus.d_fill_we) && bus.fill_word == w) begin
                seen = 1'b1; break;
            end
        end
        chk("fill_word_seen", {31'd0, seen}, 32'd1);
    endtask

    // Memory model: read issued in cycle N returns in cycle N+4.
    initial begin
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = 16'd0; end
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 16'd0;
        forever begin
            @(posedge clk); #1;
            for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = capV;
            pa[0] = capA;
            bus.mem_valid = pv[3] | strayValid;
            bus.mem_rdata = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'hCAFE;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            capV = bus.mem_en & ~bus.mem_wr;
            capA = bus.mem_addr;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        cycle++;
        if (bus.mem_en && !bus.mem_wr) begin
            readsSeen++;
            if (bus.mem_addr[3:0] == 4'd0) firstIssue = cycle;
            chk("read_expected", {31'd0, expRdQ.size() != 0}, 32'd1);
            if (expRdQ.size() != 0) chk("read_addr", {16'd0, bus.mem_addr}, {16'd0, expRdQ.pop_front()});
        end
        if ((bus.mem_en && bus.mem_wr) || bus.d_wr_ack) begin
            writesSeen++;
            chk("write_expected", {31'd0, expWrQ.size() != 0}, 32'd1);
            if (expWrQ.size() != 0) chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, expWrQ.pop_front());
            chk("write_ctl", {29'd0, bus.mem_en, bus.mem_wr, bus.d_wr_ack}, 32'd7);
        end else begin
            chk("idle_wr_zero", {15'd0, bus.mem_wr, bus.mem_wdata}, 32'd0);
        end
        if (bus.i_fill_we || bus.d_fill_we) begin
            fill_t f;
            if (bus.d_fill_we) dFillSeen++;
            chk("fill_we_exclusive", {31'd0, bus.i_fill_we & bus.d_fill_we}, 32'd0);
            chk("fill_expected", {31'd0, expFillQ.size() != 0}, 32'd1);
            if (expFillQ.size() != 0) begin
                f = expFillQ.pop_front();
                chk("fill", {12'd0, bus.d_fill_we, bus.fill_word, bus.fill_data},
                    {12'd0, f.owner, f.word, f.data});
            end
        end else begin
            chk("fill_data_zero", {16'd0, bus.fill_data}, 32'd0);
        end
        if (bus.i_done || bus.d_done) begin
            logic o;
            chk("done_expected", {31'd0, expDoneQ.size() != 0}, 32'd1);
            if (expDoneQ.size() != 0) begin
                o = expDoneQ.pop_front();
                chk("done_owner", {30'd0, bus.d_done, bus.i_done}, o ? 32'd2 : 32'd1);
                chk("done_latency", 32'(cycle - firstIssue), 32'd12);
            end
        end
    end

    initial begin
        int rd0;
        int wr0;
        int df0;
        fill_t f;
        bus.i_miss = 1'b0; bus.i_addr = 16'd0;
        bus.d_miss = 1'b0; bus.d_addr = 16'd0;
        bus.d_wr   = 1'b0; bus.d_wdata = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {21'd0, bus.mem_en, bus.mem_wr, bus.busy, bus.i_fill_we, bus.d_fill_we,
                        bus.i_done, bus.d_done, bus.d_wr_ack, bus.fill_word}, 32'd0);
        chk("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk("rst_fill_data", {16'd0, bus.fill_data}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single I fill of block 0x0020
        expectFill(1'b0, 16'h0024);
        bus.i_addr = 16'h0024; bus.i_miss = 1'b1;
        serveI();
        repeat (3) @(posedge clk); #1;

        // Store and I miss together: store first, then the fill
        expWrQ.push_back({16'h1002, 16'hBEEF});
        expectFill(1'b0, 16'h0100);
        rd0 = readsSeen;
        bus.d_addr = 16'h1002; bus.d_wdata = 16'hBEEF; bus.d_wr = 1'b1;
        bus.i_addr = 16'h0100; bus.i_miss = 1'b1;
        fork
            begin
                serveW();
                chk("write_before_fill", 32'(readsSeen), 32'(rd0));
            end
            serveI();
        join
        repeat (3) @(posedge clk); #1;

        // D and I miss together: D first, I granted on d_done cycle
        expectFill(1'b1, 16'h0344);
        expectFill(1'b0, 16'h0456);
        bus.d_addr = 16'h0344; bus.d_miss = 1'b1;
        bus.i_addr = 16'h0456; bus.i_miss = 1'b1;
        fork
            begin
                serveD();
                chk("i_fill_follows_d_done", {14'd0, bus.busy, bus.mem_en, bus.mem_addr}, {14'd0, 2'b11, 16'h0450});
            end
            serveI();
        join
        repeat (3) @(posedge clk); #1;

        // Store arriving mid I fill waits for i_done
        expectFill(1'b0, 16'h0800);
        bus.i_addr = 16'h0800; bus.i_miss = 1'b1;
        waitFill(3'd3);
        expWrQ.push_back({16'h2222, 16'h7777});
        bus.d_addr = 16'h2222; bus.d_wdata = 16'h7777; bus.d_wr = 1'b1;
        wr0 = writesSeen;
        serveI();
        chk("write_after_i_done", 32'(writesSeen), 32'(wr0));
        serveW();
        repeat (3) @(posedge clk); #1;

        // Reset during return r=4: no further fills, no done
        for (int k = 0; k < 8; k++) expRdQ.push_back(16'h0A00 + 16'(2 * k));
        for (int k = 0; k < 5; k++) begin
            f.owner = 1'b0;
            f.word  = 3'(k);
            f.data  = (16'h0A00 + 16'(2 * k)) ^ 16'h5A5A;
            expFillQ.push_back(f);
        end
        bus.i_addr = 16'h0A00; bus.i_miss = 1'b1;
        waitFill(3'd3);
        @(posedge clk); #1;
        rst_n = 1'b0; bus.i_miss = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_abort_outputs", {27'd0, bus.mem_en, bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        strayValid = 1'b1;
        repeat (2) @(posedge clk); #1;
        strayValid = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Back-to-back D fills across the address wrap
        expectFill(1'b1, 16'hFFF5);
        expectFill(1'b1, 16'h0003);
        df0 = dFillSeen;
        bus.d_addr = 16'hFFF5; bus.d_miss = 1'b1;
        serveD();
        bus.d_addr = 16'h0003; bus.d_miss = 1'b1;
        serveD();
        chk("d_fill_count", 32'(dFillSeen - df0), 32'd16);
        repeat (6) @(posedge clk); #1;

        chk("queues_empty", 32'(expRdQ.size() + expFillQ.size() + expWrQ.size() + expDoneQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
